// File: rtl/qmfir_mem_arb.sv
// Single-port QMFIR RAM arbiter: the FIR read stream has priority, and a pending host access
// is forced through once it has waited HOST_MAX_WAIT cycles.
module qmfir_mem_arb #(
    parameter int unsigned AW            = 14,
    parameter int unsigned DW            = 24,
    parameter int unsigned RD_LAT        = 1,
    parameter int unsigned HOST_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          host_we,
    input  logic          host_re,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          host_busy,
    output logic          host_ovf,
    input  logic          ovf_clr,
    input  logic          fir_req,
    input  logic [AW-1:0] fir_addr,
    output logic          fir_gnt,
    output logic [DW-1:0] fir_rdata,
    output logic          fir_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {H_IDLE, H_PEND, H_RD} host_state_e;

    host_state_e       state_q, state_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic [AW-1:0]     haddr_q;
    logic [DW-1:0]     hwdata_q;
    logic              hwr_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;
    logic [RD_LAT-1:0] pipe_fir_q, pipe_host_q;
    logic [DW-1:0]     host_rdata_q, fir_rdata_q;
    logic              host_rvalid_q, host_ovf_q;
    logic              busy, pulse, wait_max, host_gnt, fir_gnt_w, ovf_set;

    always_comb begin
        busy      = (state_q != H_IDLE);
        pulse     = host_we | host_re;
        wait_max  = (wait_q == CW'(HOST_MAX_WAIT));
        host_gnt  = (state_q == H_PEND) && (wait_max || !fir_req);
        fir_gnt_w = fir_req && !host_gnt;
        // Simultaneous we/re from idle also counts as a lost pulse.
        ovf_set   = (pulse && busy) || (host_we && host_re);
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            H_IDLE: begin
                wait_d = '0;
                if (pulse) state_d = H_PEND;
            end
            H_PEND: begin
                if (host_gnt) begin
                    state_d = hwr_q ? H_IDLE : H_RD;
                    wait_d  = '0;
                end else if (!wait_max) begin
                    wait_d = wait_q + CW'(1);
                end
            end
            H_RD: begin
                if (pipe_host_q[RD_LAT-1]) state_d = H_IDLE;
            end
            default: state_d = H_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = host_gnt | fir_gnt_w;
        mem_we    = host_gnt & hwr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (host_gnt) begin
            mem_addr  = haddr_q;
            mem_wdata = hwdata_q;
        end else if (fir_gnt_w) begin
            mem_addr = fir_addr;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= H_IDLE;
            wait_q        <= '0;
            haddr_q       <= '0;
            hwdata_q      <= '0;
            hwr_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            pipe_fir_q    <= '0;
            pipe_host_q   <= '0;
            host_rdata_q  <= '0;
            fir_rdata_q   <= '0;
            host_rvalid_q <= 1'b0;
            host_ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == H_IDLE && pulse) begin
                haddr_q  <= host_addr;
                hwdata_q <= host_wdata;
                hwr_q    <= host_we;
            end
            addr_q         <= mem_addr;
            wdata_q        <= mem_wdata;
            pipe_fir_q[0]  <= fir_gnt_w;
            pipe_host_q[0] <= host_gnt && !hwr_q;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_fir_q[i]  <= pipe_fir_q[i-1];
                pipe_host_q[i] <= pipe_host_q[i-1];
            end
            host_rvalid_q <= pipe_host_q[RD_LAT-1];
            if (pipe_host_q[RD_LAT-1]) host_rdata_q <= mem_rdata;
            if (fir_rvalid) fir_rdata_q <= mem_rdata;
            if (ovf_set) host_ovf_q <= 1'b1;
            else if (ovf_clr) host_ovf_q <= 1'b0;
        end
    end

    // FIR data is forwarded in its valid cycle and held afterwards, keeping the stream at RD_LAT.
    assign fir_rvalid  = pipe_fir_q[RD_LAT-1];
    assign fir_rdata   = fir_rvalid ? mem_rdata : fir_rdata_q;
    assign fir_gnt     = fir_gnt_w;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign host_busy   = busy;
    assign host_ovf    = host_ovf_q;

endmodule

// File: tb/tb_qmfir_mem_arb.sv
// Scoreboarded bench for qmfir_mem_arb: two instances (RD_LAT 1 and 2) share stimulus,
// each with its own RAM model; read data is checked by a monitor against queued expectations.
module tb_qmfir_mem_arb;
    localparam int AW = 14;
    localparam int DW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arst_n, host_we, host_re, ovf_clr, fir_req;
    logic [AW-1:0] host_addr, fir_addr;
    logic [DW-1:0] host_wdata;

    logic [DW-1:0] h_rdata1, f_rdata1, m_wdata1, m_rdata1;
    logic [AW-1:0] m_addr1;
    logic          h_rvalid1, busy1, ovf1, f_gnt1, f_rvalid1, m_en1, m_we1;
    logic [DW-1:0] h_rdata2, f_rdata2, m_wdata2, m_rdata2;
    logic [AW-1:0] m_addr2;
    logic          h_rvalid2, busy2, ovf2, f_gnt2, f_rvalid2, m_en2, m_we2;

    qmfir_mem_arb #(.AW(AW), .DW(DW), .RD_LAT(1), .HOST_MAX_WAIT(4)) u_dut1 (
        .clk(clk), .arst_n(arst_n), .host_we(host_we), .host_re(host_re),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(h_rdata1),
        .host_rvalid(h_rvalid1), .host_busy(busy1), .host_ovf(ovf1), .ovf_clr(ovf_clr),
        .fir_req(fir_req), .fir_addr(fir_addr), .fir_gnt(f_gnt1), .fir_rdata(f_rdata1),
        .fir_rvalid(f_rvalid1), .mem_en(m_en1), .mem_we(m_we1), .mem_addr(m_addr1),
        .mem_wdata(m_wdata1), .mem_rdata(m_rdata1)
    );

    qmfir_mem_arb #(.AW(AW), .DW(DW), .RD_LAT(2), .HOST_MAX_WAIT(4)) u_dut2 (
        .clk(clk), .arst_n(arst_n), .host_we(host_we), .host_re(host_re),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(h_rdata2),
        .host_rvalid(h_rvalid2), .host_busy(busy2), .host_ovf(ovf2), .ovf_clr(ovf_clr),
        .fir_req(fir_req), .fir_addr(fir_addr), .fir_gnt(f_gnt2), .fir_rdata(f_rdata2),
        .fir_rvalid(f_rvalid2), .mem_en(m_en2), .mem_we(m_we2), .mem_addr(m_addr2),
        .mem_wdata(m_wdata2), .mem_rdata(m_rdata2)
    );

    // Known initial RAM contents; addresses read in the tests are never written.
    function automatic logic [DW-1:0] exp_val(input logic [AW-1:0] a);
        if (a == 14'h0040) return 24'h123456;
        return {10'h2A5, a};
    endfunction

    logic [DW-1:0] ram1 [0:(1<<AW)-1];
    logic [DW-1:0] ram2 [0:(1<<AW)-1];
    logic [DW-1:0] rd1, rd2a, rd2b;

    always @(posedge clk) begin
        if (m_en1 && m_we1) ram1[m_addr1] <= m_wdata1;
        rd1 <= ram1[m_addr1];
    end
    always @(posedge clk) begin
        if (m_en2 && m_we2) ram2[m_addr2] <= m_wdata2;
        rd2a <= ram2[m_addr2];
        rd2b <= rd2a;
    end
    assign m_rdata1 = rd1;
    assign m_rdata2 = rd2b;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] hq1[$], hq2[$], fq1[$], fq2[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexp(input string name);
        checks++;
        errors++;
        $display("FAIL %s: rvalid with no expected entry at %0t", name, $time);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_d1"}, {h_rdata1, f_rdata1}, 64'h0);
        chk({tag, "_c1"}, {m_addr1, m_wdata1, h_rvalid1, busy1, ovf1, f_gnt1, f_rvalid1,
                           m_en1, m_we1}, 64'h0);
        chk({tag, "_d2"}, {h_rdata2, f_rdata2}, 64'h0);
        chk({tag, "_c2"}, {m_addr2, m_wdata2, h_rvalid2, busy2, ovf2, f_gnt2, f_rvalid2,
                           m_en2, m_we2}, 64'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Expected FIR data is queued at each grant, for the address the FIR presented.
    always @(negedge clk) begin
        if (arst_n) begin
            if (f_gnt1) fq1.push_back(exp_val(fir_addr));
            if (f_gnt2) fq2.push_back(exp_val(fir_addr));
        end
    end

    always @(negedge clk) begin
        if (arst_n) begin
            if (h_rvalid1) begin
                if (hq1.size() == 0) unexp("host_rd1");
                else chk("host_rd1", h_rdata1, hq1.pop_front());
            end
            if (h_rvalid2) begin
                if (hq2.size() == 0) unexp("host_rd2");
                else chk("host_rd2", h_rdata2, hq2.pop_front());
            end
            if (f_rvalid1) begin
                if (fq1.size() == 0) unexp("fir_rd1");
                else chk("fir_rd1", f_rdata1, fq1.pop_front());
            end
            if (f_rvalid2) begin
                if (fq2.size() == 0) unexp("fir_rd2");
                else chk("fir_rd2", f_rdata2, fq2.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram1[i] = exp_val(AW'(i));
            ram2[i] = exp_val(AW'(i));
        end
        arst_n = 1'b0; host_we = 1'b0; host_re = 1'b0; ovf_clr = 1'b0; fir_req = 1'b0;
        host_addr = '0; fir_addr = '0; host_wdata = '0;
        #2;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        repeat (2) step();

        // Host write with idle FIR
        step(); host_we = 1'b1; host_addr = 14'h0012; host_wdata = 24'hA5A5A5;
        step(); host_we = 1'b0;
        mid();
        chk("wr_en", {m_en1, m_we1, m_en2, m_we2}, 64'hF);
        chk("wr_addr", m_addr1, 64'h0012);
        chk("wr_data", m_wdata1, 64'hA5A5A5);
        chk("wr_busy", busy1, 64'h1);
        step(); mid();
        chk("wr_busy_clr", {busy1, busy2, m_en1}, 64'h0);
        chk("addr_hold", m_addr1, 64'h0012);
        repeat (2) step();

        // Host read with idle FIR
        step(); host_re = 1'b1; host_addr = 14'h0040;
        hq1.push_back(24'h123456); hq2.push_back(24'h123456);
        step(); host_re = 1'b0;
        mid();
        chk("rd_issue", {m_en1, m_we1, m_addr1}, {2'b10, 14'h0040});
        step(); mid();
        chk("rd_c2", {h_rvalid1, busy1}, 64'h1);
        step(); mid();
        chk("rd_c3_v1", {h_rvalid1, busy1, h_rvalid2}, 64'h4);
        chk("rd_c3_data1", h_rdata1, 64'h123456);
        step(); mid();
        chk("rd_c4", {h_rvalid1, h_rvalid2}, 64'h1);
        chk("rd_hold1", h_rdata1, 64'h123456);
        repeat (3) step();

        // Host starvation bound under a continuous FIR stream
        step(); fir_req = 1'b1; fir_addr = 14'h0100; host_re = 1'b1; host_addr = 14'h0041;
        hq1.push_back(24'hA94041); hq2.push_back(24'hA94041);
        mid();
        chk("stv_c0", f_gnt1, 64'h1);
        step(); host_re = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            mid();
            chk($sformatf("stv_gnt_c%0d", k), {f_gnt1, f_gnt2}, (k == 5) ? 64'h0 : 64'h3);
            chk($sformatf("stv_addr_c%0d", k), {m_en1, m_we1, m_addr1},
                (k == 5) ? {2'b10, 14'h0041} : {2'b10, 14'h0100});
            step();
        end
        fir_req = 1'b0;
        repeat (5) step();

        // Back-to-back FIR stream, addresses 0..7
        for (int k = 0; k < 12; k++) begin
            step();
            fir_req  = (k < 8);
            fir_addr = (k < 8) ? AW'(k) : '0;
            mid();
            chk($sformatf("fs_gnt_%0d", k), f_gnt2, (k < 8) ? 64'h1 : 64'h0);
            chk($sformatf("fs_rv2_%0d", k), f_rvalid2, (k >= 2 && k <= 9) ? 64'h1 : 64'h0);
            chk($sformatf("fs_rv1_%0d", k), f_rvalid1, (k >= 1 && k <= 8) ? 64'h1 : 64'h0);
            if (k == 2) chk("fs_first", f_rdata2, 64'hA94000);
            if (k == 9) chk("fs_last", f_rdata2, 64'hA94007);
            if (k == 10) chk("fs_hold", f_rdata2, 64'hA94007);
        end
        repeat (3) step();

        // Pulse while busy is dropped and flags overflow; clear
        step(); host_re = 1'b1; host_addr = 14'h0042;
        hq1.push_back(24'hA94042); hq2.push_back(24'hA94042);
        step(); host_re = 1'b0; host_we = 1'b1; host_addr = 14'h0055; host_wdata = 24'hFFFFFF;
        mid();
        chk("ovf_c1", {m_we1, ovf1, m_addr1}, {2'b00, 14'h0042});
        step(); host_we = 1'b0; ovf_clr = 1'b1;
        mid();
        chk("ovf_set", {ovf1, ovf2, m_we1, m_we2}, 64'hC);
        step(); ovf_clr = 1'b0;
        mid();
        chk("ovf_clr", {ovf1, ovf2}, 64'h0);
        repeat (4) step();

        // Simultaneous we/re: write wins, overflow sets; set beats clear in the same cycle
        step(); host_we = 1'b1; host_re = 1'b1; host_addr = 14'h0020; host_wdata = 24'h00BEEF;
        step(); host_we = 1'b0; host_addr = 14'h0043; ovf_clr = 1'b1;
        mid();
        chk("both_wr", {m_en1, m_we1, m_addr1}, {2'b11, 14'h0020});
        chk("both_data", m_wdata1, 64'h00BEEF);
        chk("both_ovf", ovf1, 64'h1);
        step(); host_re = 1'b0; ovf_clr = 1'b0;
        mid();
        chk("set_wins", {ovf1, busy1, ovf2, busy2}, 64'hA);
        step(); ovf_clr = 1'b1;
        step(); ovf_clr = 1'b0;
        mid();
        chk("ovf_clr2", {ovf1, ovf2}, 64'h0);
        repeat (3) step();

        // Reset one cycle after a host read grant discards the read
        step(); host_re = 1'b1; host_addr = 14'h0044;
        step(); host_re = 1'b0;
        mid();
        chk("rst_grant", {m_en1, m_addr1}, {1'b1, 14'h0044});
        step(); arst_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) step();
        arst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(); mid();
            chk($sformatf("post_rst_%0d", k), {busy1, busy2, h_rvalid1, h_rvalid2}, 64'h0);
        end

        chk("hq1_empty", hq1.size(), 64'h0);
        chk("hq2_empty", hq2.size(), 64'h0);
        chk("fq1_empty", fq1.size(), 64'h0);
        chk("fq2_empty", fq2.size(), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
